// File: rtl/mem_access_sequencer.sv
// Multi-cycle memory access sequencer: arbitrates instruction fetch and data
// load/store onto a single memory port with programmable wait states,
// little-endian byte-lane steering, load extension and misalignment faults.
module mem_access_sequencer #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned INSTR_WIDTH = 16,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        fetch_req,
  input  logic [ADDR_WIDTH-1:0]       fetch_addr,
  output logic [INSTR_WIDTH-1:0]      fetch_data,
  output logic                        fetch_ready,
  input  logic                        data_req,
  input  logic                        data_we,
  input  logic [1:0]                  data_size,
  input  logic                        data_signed,
  input  logic [ADDR_WIDTH-1:0]       data_addr,
  input  logic [DATA_WIDTH-1:0]       data_wdata,
  output logic [DATA_WIDTH-1:0]       data_rdata,
  output logic                        data_ready,
  output logic                        data_fault,
  output logic [ADDR_WIDTH-1:0]       mem_addr,
  output logic [DATA_WIDTH/8-1:0]     mem_be,
  output logic [DATA_WIDTH-1:0]       mem_wdata,
  input  logic [DATA_WIDTH-1:0]       mem_rdata,
  output logic                        busy
);

  localparam int unsigned LANES = DATA_WIDTH / 8;
  localparam int unsigned OFFW  = $clog2(LANES);
  localparam int unsigned CNTW  = 4;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(WAIT_STATES);
  localparam logic [CNTW-1:0] CNT_PRE  = CNTW'(WAIT_STATES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t                  state;
  logic [CNTW-1:0]         cnt;
  logic [OFFW-1:0]         lat_off;
  logic [1:0]              lat_size;
  logic                    lat_signed;
  logic                    lat_we;
  logic                    lat_is_data;
  logic                    lat_fault;
  logic [DATA_WIDTH-1:0]   lat_wdata;
  logic [DATA_WIDTH-1:0]   rbuf;

  logic                    take_data_c;
  logic                    take_fetch_c;
  logic                    data_misaligned_c;

  // Byte enables for an access of the given size at lane offset k.
  function automatic logic [LANES-1:0] lane_be(input logic [OFFW-1:0] k,
                                               input logic [1:0] size);
    case (size)
      2'd0:    lane_be = LANES'(1) << k;
      2'd1:    lane_be = LANES'(3) << k;
      default: lane_be = LANES'(15) << k;
    endcase
  endfunction

  // Right-aligned store data moved onto its byte lanes; bytes go to every lane.
  function automatic logic [DATA_WIDTH-1:0] lane_wdata(input logic [OFFW-1:0] k,
                                                       input logic [1:0] size,
                                                       input logic [DATA_WIDTH-1:0] wd);
    case (size)
      2'd0:    lane_wdata = {LANES{wd[7:0]}};
      2'd1:    lane_wdata = DATA_WIDTH'(wd[15:0]) << {k, 3'b000};
      default: lane_wdata = DATA_WIDTH'(wd[31:0]) << {k, 3'b000};
    endcase
  endfunction

  // Selected lanes right-aligned, upper bits sign- or zero-filled.
  function automatic logic [DATA_WIDTH-1:0] load_ext(input logic [DATA_WIDTH-1:0] rd,
                                                     input logic [OFFW-1:0] k,
                                                     input logic [1:0] size,
                                                     input logic sgn);
    logic [DATA_WIDTH-1:0] sh;
    int unsigned           nb;
    logic                  fill;
    sh   = rd >> {k, 3'b000};
    nb   = (size == 2'd0) ? 8 : ((size == 2'd1) ? 16 : 32);
    fill = sgn & sh[nb-1];
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      if (i >= nb) sh[i] = fill;
    end
    load_ext = sh;
  endfunction

  // Request qualification: a request is ignored while its own ready pulse is out.
  always_comb begin
    take_data_c       = data_req & ~data_ready;
    take_fetch_c      = fetch_req & ~fetch_ready & ~take_data_c;
    data_misaligned_c = (data_size == 2'd3) ||
                        ((data_size == 2'd1) && data_addr[0]) ||
                        ((data_size == 2'd2) && (data_addr[1:0] != 2'b00));
  end

  // Sequencer FSM with registered handshake and memory-side outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      lat_off     <= '0;
      lat_size    <= '0;
      lat_signed  <= 1'b0;
      lat_we      <= 1'b0;
      lat_is_data <= 1'b0;
      lat_fault   <= 1'b0;
      lat_wdata   <= '0;
      rbuf        <= '0;
      fetch_data  <= '0;
      fetch_ready <= 1'b0;
      data_rdata  <= '0;
      data_ready  <= 1'b0;
      data_fault  <= 1'b0;
      mem_addr    <= '0;
      mem_be      <= '0;
      mem_wdata   <= '0;
      busy        <= 1'b0;
    end else begin
      fetch_ready <= 1'b0;
      data_ready  <= 1'b0;
      data_fault  <= 1'b0;
      mem_be      <= '0;
      mem_wdata   <= '0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (take_data_c) begin
            lat_off     <= data_addr[OFFW-1:0];
            lat_size    <= data_size;
            lat_signed  <= data_signed;
            lat_we      <= data_we;
            lat_is_data <= 1'b1;
            lat_wdata   <= data_wdata;
            busy        <= 1'b1;
            if (data_misaligned_c) begin
              lat_fault <= 1'b1;
              state     <= DONE;
            end else begin
              lat_fault <= 1'b0;
              state     <= ACCESS;
              mem_addr  <= {data_addr[ADDR_WIDTH-1:OFFW], OFFW'(0)};
              if ((CNT_LAST == '0) && data_we) begin
                mem_be    <= lane_be(data_addr[OFFW-1:0], data_size);
                mem_wdata <= lane_wdata(data_addr[OFFW-1:0], data_size, data_wdata);
              end
            end
          end else if (take_fetch_c) begin
            lat_off     <= {fetch_addr[OFFW-1:1], 1'b0};
            lat_size    <= 2'd1;
            lat_signed  <= 1'b0;
            lat_we      <= 1'b0;
            lat_is_data <= 1'b0;
            lat_fault   <= 1'b0;
            busy        <= 1'b1;
            state       <= ACCESS;
            mem_addr    <= {fetch_addr[ADDR_WIDTH-1:OFFW], OFFW'(0)};
          end
        end
        ACCESS: begin
          if (cnt == CNT_LAST) begin
            rbuf  <= mem_rdata;
            state <= DONE;
          end else begin
            cnt <= cnt + CNTW'(1);
            if ((cnt == CNT_PRE) && lat_we) begin
              mem_be    <= lane_be(lat_off, lat_size);
              mem_wdata <= lane_wdata(lat_off, lat_size, lat_wdata);
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          cnt   <= '0;
          if (lat_is_data) begin
            data_ready <= 1'b1;
            data_fault <= lat_fault;
            if (!lat_fault && !lat_we) begin
              data_rdata <= load_ext(rbuf, lat_off, lat_size, lat_signed);
            end
          end else begin
            fetch_ready <= 1'b1;
            fetch_data  <= INSTR_WIDTH'(rbuf >> {lat_off, 3'b000});
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Self-checking bench for mem_access_sequencer (32-bit data, WAIT_STATES=1).
module tb_mem_access_sequencer;

  localparam int WS = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_req = 1'b0;
  logic [31:0] fetch_addr = '0;
  logic [15:0] fetch_data;
  logic        fetch_ready;
  logic        data_req = 1'b0;
  logic        data_we = 1'b0;
  logic [1:0]  data_size = '0;
  logic        data_signed = 1'b0;
  logic [31:0] data_addr = '0;
  logic [31:0] data_wdata = '0;
  logic [31:0] data_rdata;
  logic        data_ready;
  logic        data_fault;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] last_rdata = '0;

  always #5 clk = ~clk;

  mem_access_sequencer #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .INSTR_WIDTH(16), .WAIT_STATES(WS)
  ) dut (
    .clock(clk), .reset(rst_n),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_data(fetch_data),
    .fetch_ready(fetch_ready),
    .data_req(data_req), .data_we(data_we), .data_size(data_size),
    .data_signed(data_signed), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_rdata(data_rdata), .data_ready(data_ready), .data_fault(data_fault),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  // Reference: extended load value from plain arithmetic.
  function automatic logic [31:0] ref_load(input logic [31:0] rd, input int k,
                                           input int sz, input bit sg);
    logic [31:0] v;
    v = rd >> (8 * k);
    if (sz == 0) begin
      v = v & 32'hFF;
      if (sg && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (sz == 1) begin
      v = v & 32'hFFFF;
      if (sg && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  function automatic bit ref_misaligned(input logic [31:0] a, input int sz);
    return (sz == 3) || (sz == 1 && (a % 2) != 0) || (sz == 2 && (a % 4) != 0);
  endfunction

  // Drive one load/store and observe it until data_ready (bounded).
  task automatic do_data(input bit we, input logic [1:0] sz, input bit sg,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                         output logic [31:0] o_rdata, output bit o_fault, output int o_lat,
                         output int o_nbe, output logic [3:0] o_be, output logic [31:0] o_wd,
                         output logic [31:0] o_addr, output int o_busy, output bit o_to);
    bit done = 0;
    data_we = we; data_size = sz; data_signed = sg; data_addr = a; data_wdata = wd;
    mem_rdata = rd; data_req = 1'b1;
    o_lat = 0; o_nbe = 0; o_be = '0; o_wd = '0; o_addr = '0; o_busy = 0;
    o_rdata = '0; o_fault = 0;
    while (!done && o_lat < 50) begin
      @(negedge clk);
      o_lat++;
      if (busy) o_busy++;
      if (mem_be != 4'b0) begin
        o_nbe++; o_be = mem_be; o_wd = mem_wdata; o_addr = mem_addr;
      end
      if (data_ready) begin
        done = 1; o_rdata = data_rdata; o_fault = data_fault;
      end
    end
    data_req = 1'b0;
    o_to = !done;
    @(negedge clk);
  endtask

  task automatic do_fetch(input logic [31:0] a, input logic [31:0] rd,
                          output logic [15:0] o_data, output int o_lat, output int o_nbe,
                          output bit o_to);
    bit done = 0;
    fetch_addr = a; mem_rdata = rd; fetch_req = 1'b1;
    o_lat = 0; o_nbe = 0; o_data = '0;
    while (!done && o_lat < 50) begin
      @(negedge clk);
      o_lat++;
      if (mem_be != 4'b0) o_nbe++;
      if (fetch_ready) begin done = 1; o_data = fetch_data; end
    end
    fetch_req = 1'b0;
    o_to = !done;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({fetch_ready, data_ready, data_fault, busy} !== 4'b0) begin
      n_fail++; $display("FAIL reset_flags got=%b exp=0000", {fetch_ready, data_ready, data_fault, busy});
    end
    n_tests++;
    if ({mem_be, mem_addr, mem_wdata} !== '0) begin
      n_fail++; $display("FAIL reset_mem got be=%h addr=%h wd=%h exp=0", mem_be, mem_addr, mem_wdata);
    end
    n_tests++;
    if ({data_rdata, fetch_data} !== '0) begin
      n_fail++; $display("FAIL reset_data got rdata=%h fdata=%h exp=0", data_rdata, fetch_data);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fetch();
    logic [15:0] d; int lat, nbe; bit to;
    do_fetch(32'h0000_0102, 32'hAABB_CCDD, d, lat, nbe, to);
    n_tests++;
    if (to || lat != WS + 3) begin
      n_fail++; $display("FAIL fetch_latency got=%0d timeout=%0d exp=%0d", lat, to, WS + 3);
    end
    n_tests++;
    if (d !== 16'hAABB) begin n_fail++; $display("FAIL fetch_data got=%h exp=aabb", d); end
    n_tests++;
    if (nbe != 0) begin n_fail++; $display("FAIL fetch_be got=%0d exp=0", nbe); end
  endtask

  task automatic test_load_ext();
    logic [31:0] r, w, ad; logic [3:0] be; bit f, to; int lat, nbe, bz;
    do_data(0, 2'd0, 1, 32'h13, 32'h0, 32'h80FF_0000, r, f, lat, nbe, be, w, ad, bz, to);
    n_tests++;
    if (to || r !== 32'hFFFF_FF80 || f) begin
      n_fail++; $display("FAIL load_byte_signed got=%h fault=%0d exp=ffffff80", r, f);
    end
    n_tests++;
    if (lat != WS + 3) begin n_fail++; $display("FAIL load_latency got=%0d exp=%0d", lat, WS + 3); end
    do_data(0, 2'd0, 0, 32'h13, 32'h0, 32'h80FF_0000, r, f, lat, nbe, be, w, ad, bz, to);
    n_tests++;
    if (to || r !== 32'h0000_0080) begin
      n_fail++; $display("FAIL load_byte_unsigned got=%h exp=00000080", r);
    end
    last_rdata = 32'h0000_0080;
  endtask

  task automatic test_store_half();
    logic [31:0] r, w, ad; logic [3:0] be; bit f, to; int lat, nbe, bz;
    do_data(1, 2'd1, 0, 32'h22, 32'h0000_1234, 32'h0, r, f, lat, nbe, be, w, ad, bz, to);
    n_tests++;
    if (to || nbe != 1 || be !== 4'b1100) begin
      n_fail++; $display("FAIL store_half_be got be=%b cycles=%0d exp be=1100 cycles=1", be, nbe);
    end
    n_tests++;
    if (w[31:16] !== 16'h1234 || ad !== 32'h20) begin
      n_fail++; $display("FAIL store_half_bus got wd=%h addr=%h exp wd[31:16]=1234 addr=20", w, ad);
    end
    n_tests++;
    if (r !== last_rdata) begin n_fail++; $display("FAIL store_rdata_hold got=%h exp=%h", r, last_rdata); end
  endtask

  task automatic test_fault();
    logic [31:0] r, w, ad; logic [3:0] be; bit f, to; int lat, nbe, bz;
    do_data(0, 2'd2, 0, 32'h06, 32'h0, 32'h1234_5678, r, f, lat, nbe, be, w, ad, bz, to);
    n_tests++;
    if (to || !f || lat != 2) begin
      n_fail++; $display("FAIL fault_word got fault=%0d lat=%0d exp fault=1 lat=2", f, lat);
    end
    n_tests++;
    if (nbe != 0 || bz != 1) begin
      n_fail++; $display("FAIL fault_side got be_cycles=%0d busy=%0d exp 0 and 1", nbe, bz);
    end
    do_data(1, 2'd3, 0, 32'h00, 32'hFFFF_FFFF, 32'h0, r, f, lat, nbe, be, w, ad, bz, to);
    n_tests++;
    if (to || !f || lat != 2 || nbe != 0) begin
      n_fail++; $display("FAIL fault_size3 got fault=%0d lat=%0d be_cycles=%0d exp 1/2/0", f, lat, nbe);
    end
  endtask

  task automatic test_simultaneous();
    int cyc = 0, td = -1, tf = -1;
    data_we = 0; data_size = 2'd2; data_signed = 0; data_addr = 32'h40;
    fetch_addr = 32'h0000_0200; mem_rdata = 32'hCAFE_BEEF;
    data_req = 1; fetch_req = 1;
    while ((td < 0 || tf < 0) && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (data_ready) begin td = cyc; data_req = 0; end
      if (fetch_ready) begin tf = cyc; fetch_req = 0; end
    end
    data_req = 0; fetch_req = 0;
    @(negedge clk);
    n_tests++;
    if (td != WS + 3) begin n_fail++; $display("FAIL simul_data_first got=%0d exp=%0d", td, WS + 3); end
    n_tests++;
    if (tf != td + WS + 3) begin
      n_fail++; $display("FAIL simul_fetch_after got=%0d exp=%0d", tf, td + WS + 3);
    end
    n_tests++;
    if (data_rdata !== 32'hCAFE_BEEF || fetch_data !== 16'hBEEF) begin
      n_fail++; $display("FAIL simul_values got rdata=%h fdata=%h exp cafebeef/beef", data_rdata, fetch_data);
    end
    last_rdata = 32'hCAFE_BEEF;
  endtask

  task automatic test_random();
    logic [31:0] r, w, ad, a, wd, rd, exp_w; logic [3:0] be, exp_be; logic [15:0] fd;
    bit f, to, sg, we, mis; int lat, nbe, bz, sz, k, kind;
    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 3);
      a = $urandom; rd = $urandom; wd = $urandom;
      if (kind == 0) begin
        a[0] = 1'b0;
        do_fetch(a, rd, fd, lat, nbe, to);
        n_tests++;
        if (to || lat != WS + 3 || nbe != 0 || fd !== 16'((rd >> (8 * (a % 4))) & 32'hFFFF)) begin
          n_fail++;
          $display("FAIL rnd_fetch[%0d] addr=%h got=%h lat=%0d exp=%h", i, a, fd, lat,
                   16'((rd >> (8 * (a % 4))) & 32'hFFFF));
        end
      end else begin
        we = (kind == 1); sg = $urandom_range(0, 1);
        sz = (i % 5 == 0) ? $urandom_range(0, 3) : $urandom_range(0, 2);
        if ($urandom_range(0, 3) != 0) a = a & ~((sz == 2) ? 32'h3 : (sz == 1) ? 32'h1 : 32'h0);
        k = a % 4;
        mis = ref_misaligned(a, sz);
        do_data(we, 2'(sz), sg, a, wd, rd, r, f, lat, nbe, be, w, ad, bz, to);
        n_tests++;
        if (to || f != mis || lat != (mis ? 2 : WS + 3)) begin
          n_fail++;
          $display("FAIL rnd_handshake[%0d] addr=%h sz=%0d got fault=%0d lat=%0d exp fault=%0d lat=%0d",
                   i, a, sz, f, lat, mis, mis ? 2 : WS + 3);
        end
        if (!mis && !we) last_rdata = ref_load(rd, k, sz, sg);
        n_tests++;
        if (r !== last_rdata) begin
          n_fail++; $display("FAIL rnd_rdata[%0d] addr=%h sz=%0d sg=%0d got=%h exp=%h", i, a, sz, sg, r, last_rdata);
        end
        if (we && !mis) begin
          exp_be = (sz == 0) ? 4'(1 << k) : (sz == 1) ? 4'(3 << k) : 4'hF;
          exp_w  = (sz == 0) ? (wd & 32'hFF) * 32'h0101_0101 :
                   (sz == 1) ? (wd & 32'hFFFF) << (8 * k) : wd;
          n_tests++;
          if (nbe != 1 || be !== exp_be || w !== exp_w || ad !== (a & ~32'h3)) begin
            n_fail++;
            $display("FAIL rnd_store[%0d] got be=%b n=%0d wd=%h addr=%h exp be=%b wd=%h addr=%h",
                     i, be, nbe, w, ad, exp_be, exp_w, a & ~32'h3);
          end
        end else begin
          n_tests++;
          if (nbe != 0) begin n_fail++; $display("FAIL rnd_nobe[%0d] got=%0d exp=0", i, nbe); end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] d; int lat, nbe, seen = 0; bit to;
    bit saw_ready = 0;
    data_we = 1; data_size = 2'd2; data_addr = 32'h100; data_wdata = 32'h5555_AAAA;
    data_req = 1;
    while (seen == 0 && lat < 20) begin
      @(negedge clk); lat++;
      if (mem_be != 4'b0) seen = 1;
    end
    n_tests++;
    if (seen == 0) begin n_fail++; $display("FAIL rstmid_be_seen got=0 exp=1"); end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (mem_be !== 4'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_async got be=%b busy=%b exp 0000/0", mem_be, busy);
    end
    data_req = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (data_ready || fetch_ready) saw_ready = 1;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (data_ready || fetch_ready || busy) saw_ready = 1;
    end
    n_tests++;
    if (saw_ready) begin n_fail++; $display("FAIL rstmid_no_ready got activity=1 exp=0"); end
    do_fetch(32'h0000_0010, 32'h1357_9BDF, d, lat, nbe, to);
    n_tests++;
    if (to || lat != WS + 3 || d !== 16'h9BDF) begin
      n_fail++; $display("FAIL rstmid_recover got=%h lat=%0d exp=9bdf lat=%0d", d, lat, WS + 3);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_fetch();
    test_load_ext();
    test_store_half();
    test_fault();
    test_simultaneous();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
